cofi_ng: RTL and testbench

//  Parametrised composite-style horizontal colour blender, successor to the 2-tap blend filter.

---
 rtl/cofi_pkg.sv | 13 +
 rtl/cofi_ng_chan.sv | 60 ++++++
 rtl/cofi_ng.sv | 93 +++++++++
 tb/tb_cofi_ng.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cofi_pkg.sv
// rtl/cofi_pkg.sv - shared mode encodings and helpers for the cofi_ng colour blender
package cofi_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_2TAP   = 2'd1;
  localparam logic [1:0] MODE_3TAP   = 2'd2;

  // The unused encoding 3 is folded onto bypass so the datapath only ever sees legal modes.
  function automatic logic [1:0] mode_sanitise(input logic [1:0] m);
    return (m == 2'd3) ? MODE_BYPASS : m;
  endfunction

endpackage

// File: rtl/cofi_ng_chan.sv
// rtl/cofi_ng_chan.sv - one colour channel of the cofi_ng horizontal blender
//
// Holds the two-pixel history (d1 = centre, d2 = left) and the output register.
// The blank flags are owned by the top and shared by all channels.
//   clk, reset_n, pix_ce : clock, sync active-low reset, pixel enable
//   mode_i               : sanitised active mode
//   b1_i / b2_i          : centre / left history pixel was in hblank
//   r_blank_i            : current input (right neighbour) is in hblank
//   pix_i / pix_o        : channel input sample / filtered channel output
module cofi_ng_chan #(
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_ce,
  input  logic [1:0]    mode_i,
  input  logic          b1_i,
  input  logic          b2_i,
  input  logic          r_blank_i,
  input  logic [DW-1:0] pix_i,
  output logic [DW-1:0] pix_o
);
  import cofi_pkg::*;

  logic [DW-1:0] d1_q, d2_q, out_q, out_d;
  logic [DW-1:0] l_pix, r_pix;
  logic [DW+1:0] sum2, sum3;

  always_comb begin
    // Blank neighbours are replaced by the centre so nothing from blanking or
    // the previous line can bleed into an active pixel.
    l_pix = b2_i ? d1_q : d2_q;
    r_pix = r_blank_i ? d1_q : pix_i;
    sum2  = {2'b00, l_pix} + {2'b00, d1_q} + (DW+2)'(1);
    sum3  = {2'b00, l_pix} + {1'b0, d1_q, 1'b0} + {2'b00, r_pix} + (DW+2)'(2);
    out_d = d1_q;
    if (!b1_i) begin
      case (mode_i)
        MODE_2TAP: out_d = DW'(sum2 >> 1);
        MODE_3TAP: out_d = DW'(sum3 >> 2);
        default:   out_d = d1_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d1_q  <= '0;
      d2_q  <= '0;
      out_q <= '0;
    end else if (pix_ce) begin
      d2_q  <= d1_q;
      d1_q  <= pix_i;
      out_q <= out_d;
    end
  end

  assign pix_o = out_q;

endmodule

// File: rtl/cofi_ng.sv
// rtl/cofi_ng.sv - parametrised composite-style horizontal colour blender (top)
//
// Two-tick pipeline in every mode: input -> centre history -> output register.
// Syncs and blanks follow the same two-stage shape so they stay aligned with pix_out.
//   clk, reset_n, pix_ce      : clock, sync active-low reset, pixel enable
//   mode                      : requested mode (0 bypass, 1 2-tap, 2 3-tap, 3 bypass)
//   hblank, vblank, hs, vs    : input timing, aligned with pix_in
//   pix_in / pix_out          : CH packed channels of DW bits, channel 0 in LSBs
//   *_out                     : timing delayed to match pix_out
//   mode_act                  : mode currently applied, updated on vblank rise
module cofi_ng #(
  parameter int DW = 6,
  parameter int CH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_ce,
  input  logic [1:0]       mode,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             hs,
  input  logic             vs,
  input  logic [CH*DW-1:0] pix_in,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic [CH*DW-1:0] pix_out,
  output logic [1:0]       mode_act
);
  import cofi_pkg::*;

  // b1_q doubles as the first hblank delay stage; vb1_q doubles as the
  // previous-vblank flag used for edge detection of the mode latch.
  logic       b1_q, b2_q, vb1_q, hs1_q, vs1_q;
  logic       hblank_out_q, vblank_out_q, hs_out_q, vs_out_q;
  logic [1:0] mode_act_q, mode_act_d;

  always_comb begin
    mode_act_d = mode_act_q;
    if (vblank && !vb1_q) begin
      mode_act_d = mode_sanitise(mode);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // History flags start as blank so the first pixels after reset are a line edge.
      b1_q         <= 1'b1;
      b2_q         <= 1'b1;
      vb1_q        <= 1'b0;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      hblank_out_q <= 1'b0;
      vblank_out_q <= 1'b0;
      hs_out_q     <= 1'b0;
      vs_out_q     <= 1'b0;
      mode_act_q   <= MODE_BYPASS;
    end else if (pix_ce) begin
      b2_q         <= b1_q;
      b1_q         <= hblank;
      vb1_q        <= vblank;
      hs1_q        <= hs;
      vs1_q        <= vs;
      hblank_out_q <= b1_q;
      vblank_out_q <= vb1_q;
      hs_out_q     <= hs1_q;
      vs_out_q     <= vs1_q;
      mode_act_q   <= mode_act_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    cofi_ng_chan #(.DW(DW)) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .pix_ce   (pix_ce),
      .mode_i   (mode_act_q),
      .b1_i     (b1_q),
      .b2_i     (b2_q),
      .r_blank_i(hblank),
      .pix_i    (pix_in[c*DW +: DW]),
      .pix_o    (pix_out[c*DW +: DW])
    );
  end

  assign hblank_out = hblank_out_q;
  assign vblank_out = vblank_out_q;
  assign hs_out     = hs_out_q;
  assign vs_out     = vs_out_q;
  assign mode_act   = mode_act_q;

endmodule

// File: tb/tb_cofi_ng.sv
// tb/tb_cofi_ng.sv - self-checking bench for cofi_ng
module tb_cofi_ng;
  localparam int DW = 6;
  localparam int CH = 3;
  localparam int W  = DW * CH;

  logic         clk = 1'b0;
  logic         reset_n, pix_ce, hblank, vblank, hs, vs;
  logic [1:0]   mode;
  logic [W-1:0] pix_in;
  logic         hblank_out, vblank_out, hs_out, vs_out;
  logic [W-1:0] pix_out;
  logic [1:0]   mode_act;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cofi_ng #(.DW(DW), .CH(CH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_ce    (pix_ce),
    .mode      (mode),
    .hblank    (hblank),
    .vblank    (vblank),
    .hs        (hs),
    .vs        (vs),
    .pix_in    (pix_in),
    .hblank_out(hblank_out),
    .vblank_out(vblank_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .pix_out   (pix_out),
    .mode_act  (mode_act)
  );

  typedef struct {
    logic       hb;
    logic [5:0] px;
    logic [5:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [5:0] v);
    return {v, v, v};
  endfunction

  // One pix_ce tick: inputs applied at a falling edge, outputs sampled at the next falling edge.
  task automatic step(input logic hb, input logic vb, input logic h, input logic v,
                      input logic [W-1:0] px);
    hblank = hb; vblank = vb; hs = h; vs = v; pix_in = px;
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].hb, 1'b0, 1'b0, 1'b0, rep(tv[i].px));
      chk($sformatf("%s[%0d]", name, i), pix_out, rep(tv[i].exp));
    end
    tv.delete();
  endtask

  logic [W-1:0] hist[64];
  logic         hsh[64];
  logic         vsh[64];

  initial begin
    reset_n = 1'b0; pix_ce = 1'b0; mode = 2'd0;
    hblank = 1'b0; vblank = 1'b0; hs = 1'b0; vs = 1'b0; pix_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_pix", pix_out, 0);
    chk("rst_hs", hs_out, 0);
    chk("rst_vs", vs_out, 0);
    chk("rst_hb", hblank_out, 0);
    chk("rst_vb", vblank_out, 0);
    chk("rst_mode", mode_act, 0);
    reset_n = 1'b1;

    // Latency ramp in bypass, pix_ce every third clock, distinct channel values.
    for (int i = 0; i < 64; i++) begin
      hist[i] = {6'(i), 6'(63 - i), 6'(i ^ 21)};
      hsh[i]  = (i % 5 == 0);
      vsh[i]  = (i % 7 == 0);
      pix_ce  = 1'b0;
      repeat (2) @(negedge clk);
      if (i >= 2) chk($sformatf("idle_hold[%0d]", i), pix_out, hist[i-2]);
      step(1'b0, 1'b0, hsh[i], vsh[i], hist[i]);
      if (i >= 1) begin
        chk($sformatf("ramp_pix[%0d]", i), pix_out, hist[i-1]);
        chk($sformatf("ramp_hs[%0d]", i), hs_out, hsh[i-1]);
        chk($sformatf("ramp_vs[%0d]", i), vs_out, vsh[i-1]);
      end
    end

    // 2-tap
    set_mode(2'd1);
    chk("mode_2tap", mode_act, 1);
    tv.push_back('{1'b1, 6'd0,  6'd0});
    tv.push_back('{1'b1, 6'd0,  6'd0});
    tv.push_back('{1'b0, 6'd10, 6'd0});
    tv.push_back('{1'b0, 6'd20, 6'd10});
    tv.push_back('{1'b0, 6'd21, 6'd15});
    tv.push_back('{1'b1, 6'd0,  6'd21});
    tv.push_back('{1'b1, 6'd0,  6'd0});
    run_vecs("tap2");

    // 3-tap interior pattern followed by a short line bounded by blanking
    set_mode(2'd2);
    chk("mode_3tap", mode_act, 2);
    tv.push_back('{1'b1, 6'd0,  6'd0});
    tv.push_back('{1'b1, 6'd0,  6'd0});
    tv.push_back('{1'b0, 6'd0,  6'd0});
    tv.push_back('{1'b0, 6'd40, 6'd10});
    tv.push_back('{1'b0, 6'd0,  6'd20});
    tv.push_back('{1'b0, 6'd63, 6'd26});
    tv.push_back('{1'b0, 6'd63, 6'd47});
    tv.push_back('{1'b1, 6'd0,  6'd63});
    tv.push_back('{1'b1, 6'd0,  6'd0});
    run_vecs("tap3");
    tv.push_back('{1'b1, 6'd33, 6'd0});
    tv.push_back('{1'b1, 6'd33, 6'd33});
    tv.push_back('{1'b0, 6'd8,  6'd33});
    tv.push_back('{1'b0, 6'd8,  6'd8});
    tv.push_back('{1'b0, 6'd60, 6'd21});
    tv.push_back('{1'b1, 6'd33, 6'd47});
    tv.push_back('{1'b1, 6'd33, 6'd33});
    run_vecs("edge");

    // Saturation in every mode
    for (int m = 0; m < 3; m++) begin
      set_mode(2'(m));
      chk($sformatf("sat_mode[%0d]", m), mode_act, m);
      for (int k = 1; k <= 4; k++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, rep(6'd63));
        if (k >= 2) chk($sformatf("sat[%0d][%0d]", m, k), pix_out, rep(6'd63));
      end
    end

    // Mode latch and blank delay
    set_mode(2'd0);
    chk("ml_base", mode_act, 0);
    mode = 2'd2;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("ml_midframe1", mode_act, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("ml_midframe2", mode_act, 0);
    chk("hb_delay1", hblank_out, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("ml_rise", mode_act, 2);
    chk("vb_delay0", vblank_out, 0);
    chk("hb_delay0", hblank_out, 0);
    mode = 2'd1;
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("ml_no_rise", mode_act, 2);
    chk("vb_delay1", vblank_out, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("ml_fall", mode_act, 2);
    chk("vb_delay2", vblank_out, 1);
    mode = 2'd3;
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("ml_mode3", mode_act, 0);
    chk("vb_delay3", vblank_out, 0);

    // Mid-line reset with pix_ce low
    set_mode(2'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, rep(6'd40));
    step(1'b0, 1'b0, 1'b1, 1'b1, rep(6'd50));
    step(1'b0, 1'b0, 1'b1, 1'b1, rep(6'd50));
    chk("pre_rst_hs", hs_out, 1);
    reset_n = 1'b0;
    pix_ce  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_pix", pix_out, 0);
    chk("mid_rst_hs", hs_out, 0);
    chk("mid_rst_vs", vs_out, 0);
    chk("mid_rst_mode", mode_act, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, rep(6'd20));
    chk("post_rst0", pix_out, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, rep(6'd30));
    chk("post_rst1", pix_out, rep(6'd20));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
